// File: rtl/encrypt_collect_if.sv
// Stream bundle between the LWE accumulator side, encrypt_collect and the word consumer.
// slave is the collector's view; master is the view of whoever drives the accumulator and consumer side.
interface encrypt_collect_if #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 32,
  parameter int DIM_WIDTH        = 7,
  parameter int FIFO_AW          = 3
);
  logic                        done;
  logic [DIM_WIDTH-1:0]        row;
  logic [CIPHERTEXT_WIDTH-1:0] ciphertext;
  logic [PLAINTEXT_WIDTH-1:0]  plaintext;
  logic                        pt_load;
  logic                        out_valid;
  logic                        out_ready;
  logic [CIPHERTEXT_WIDTH-1:0] out_data;
  logic [DIM_WIDTH-1:0]        out_row;
  logic                        out_last;
  logic                        overflow;
  logic [FIFO_AW:0]            fifo_count;

  modport slave (
    input  done, row, ciphertext, plaintext, pt_load, out_ready,
    output out_valid, out_data, out_row, out_last, overflow, fifo_count
  );

  modport master (
    output done, row, ciphertext, plaintext, pt_load, out_ready,
    input  out_valid, out_data, out_row, out_last, overflow, fifo_count
  );
endinterface

// File: rtl/encrypt_collect.sv
// Captures each finished accumulator row on a row-index change, reduces it mod q, folds the scaled
// plaintext into the b term and streams the words out through a small queue with a registered head.
module encrypt_collect #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CT_MOD_WIDTH       = 10,
  parameter int CIPHERTEXT_WIDTH   = 32,
  parameter int DIM_WIDTH          = 7,
  parameter int WORDS_PER_CT       = 128,
  parameter int FIFO_DEPTH         = 8,
  parameter int FIFO_AW            = 3
) (
  input logic              clk,
  input logic              rst_n,
  encrypt_collect_if.slave bus
);
  localparam int SHIFT = CT_MOD_WIDTH - PLAINTEXT_WIDTH;
  localparam int WCW   = (WORDS_PER_CT > 1) ? $clog2(WORDS_PER_CT) : 1;
  localparam int EW    = 1 + DIM_WIDTH + CT_MOD_WIDTH;

  logic [DIM_WIDTH-1:0]       row_q;
  logic [DIM_WIDTH-1:0]       cap_idx;
  logic                       cap_pending;
  logic [PLAINTEXT_WIDTH-1:0] pt_reg;
  logic [WCW-1:0]             word_cnt;
  logic [CT_MOD_WIDTH-1:0]    ct_low;
  logic [CT_MOD_WIDTH-1:0]    pt_term;
  logic [CT_MOD_WIDTH-1:0]    cap_word;
  logic                       cap_last;
  logic                       row_changed;

  logic [EW-1:0]              mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]         wr_ptr;
  logic [FIFO_AW-1:0]         rd_ptr;
  logic [FIFO_AW:0]           mem_cnt;
  logic [FIFO_AW:0]           total_cnt;
  logic                       out_valid_r;
  logic [CT_MOD_WIDTH-1:0]    out_word_r;
  logic [DIM_WIDTH-1:0]       out_row_r;
  logic                       out_last_r;
  logic                       overflow_r;
  logic                       pop;
  logic                       full;
  logic                       accept;
  logic                       load_out;
  logic [EW-1:0]              head;
  logic                       unused_ct_high;

  assign unused_ct_high = ^bus.ciphertext[CIPHERTEXT_WIDTH-1:CT_MOD_WIDTH];

  assign ct_low      = bus.ciphertext[CT_MOD_WIDTH-1:0];
  assign pt_term     = {pt_reg, {SHIFT{1'b0}}};
  assign cap_last    = (word_cnt == WCW'(WORDS_PER_CT - 1));
  assign row_changed = (bus.row != row_q);

  // q and p are powers of two, so mod q is truncation and pt*(q/p) is a shift
  always_comb begin
    cap_word = ct_low;
    if (cap_idx == '0) cap_word = ct_low + pt_term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q       <= '0;
      cap_idx     <= '0;
      cap_pending <= 1'b0;
      pt_reg      <= '0;
      word_cnt    <= '0;
    end else begin
      if (bus.pt_load) pt_reg <= bus.plaintext;
      if (bus.done) begin
        row_q       <= '0;
        cap_pending <= 1'b0;
        word_cnt    <= '0;
      end else begin
        row_q       <= bus.row;
        cap_pending <= row_changed;
        if (row_changed) cap_idx <= row_q;
        // a dropped word still counts toward the frame position
        if (cap_pending) word_cnt <= cap_last ? '0 : word_cnt + WCW'(1);
      end
    end
  end

  // Queue capacity counts the registered head, so total occupancy never exceeds FIFO_DEPTH.
  assign total_cnt = mem_cnt + (FIFO_AW+1)'(out_valid_r);
  assign pop       = out_valid_r && bus.out_ready;
  assign full      = (total_cnt == (FIFO_AW+1)'(FIFO_DEPTH));
  assign accept    = cap_pending && (!full || pop);
  assign load_out  = (mem_cnt != '0) && (!out_valid_r || pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {cap_last, cap_idx, cap_word};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      out_valid_r <= 1'b0;
      out_word_r  <= '0;
      out_row_r   <= '0;
      out_last_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (load_out) begin
        rd_ptr      <= rd_ptr + FIFO_AW'(1);
        out_valid_r <= 1'b1;
        {out_last_r, out_row_r, out_word_r} <= head;
      end else if (pop) begin
        out_valid_r <= 1'b0;
      end
      case ({accept, load_out})
        2'b10:   mem_cnt <= mem_cnt + (FIFO_AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (FIFO_AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (cap_pending && full && !pop) overflow_r <= 1'b1;
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = {{(CIPHERTEXT_WIDTH-CT_MOD_WIDTH){1'b0}}, out_word_r};
  assign bus.out_row    = out_row_r;
  assign bus.out_last   = out_last_r;
  assign bus.overflow   = overflow_r;
  assign bus.fifo_count = total_cnt;
endmodule
